// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command encodings, FSM state
// encoding and default widths.
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int RD_WAIT_DEF = 2;
    localparam int CMD_W       = 2;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV,
        ST_END
    } state_t;

endpackage

// File: rtl/spi_master_shreg.sv
// Datapath for the SPI master: parallel-load TX register shifted out MSB first,
// and an RX register shifting MISO in from the LSB side.
module spi_master_shreg #(
    parameter int TX_W = 10,
    parameter int RX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [TX_W-1:0] load_data_i,
    input  logic            tx_shift_i,
    input  logic            rx_shift_i,
    input  logic            rx_bit_i,
    output logic            tx_bit_o,
    output logic [RX_W-1:0] rx_next_o
);

    logic [TX_W-1:0] tx_q, tx_d;
    logic [RX_W-1:0] rx_q, rx_d;

    assign tx_bit_o  = tx_q[TX_W-1];
    // Value the RX register takes after this edge's sample; lets the caller
    // capture the final byte in the same edge as the last sample.
    assign rx_next_o = {rx_q[RX_W-2:0], rx_bit_i};

    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load_i) begin
            tx_d = load_data_i;
            rx_d = '0;
        end else if (tx_shift_i) begin
            tx_d = {tx_q[TX_W-2:0], 1'b0};
        end
        if (rx_shift_i) begin
            rx_d = rx_next_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: sends a command/payload frame on MOSI and, for read-data
// commands, collects a byte from MISO after a fixed turnaround.
module spi_master
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              load, tx_shift, rx_shift, tx_bit;
    logic [DATA_W-1:0] rx_next;

    spi_master_shreg #(
        .TX_W (FRAME_W),
        .RX_W (DATA_W)
    ) u_shreg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_data_i (cmd_data),
        .tx_shift_i  (tx_shift),
        .rx_shift_i  (rx_shift),
        .rx_bit_i    (MISO),
        .tx_bit_o    (tx_bit),
        .rx_next_o   (rx_next)
    );

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        load      = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rd_valid  = 1'b0;
        SS_n      = 1'b0;
        MOSI      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                SS_n = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    rd_d    = (cmd_data[FRAME_W-1 -: CMD_W] == CMD_RD_DATA);
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_SHIFT;
            ST_SHIFT: begin
                MOSI     = tx_bit;
                tx_shift = 1'b1;
                if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    if (!rd_q)             state_d = ST_END;
                    else if (RD_WAIT == 0) state_d = ST_RECV;
                    else                   state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(RD_WAIT - 1)) state_d = ST_RECV;
            end
            ST_RECV: begin
                rx_shift = 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d   = ST_END;
                    rd_data_d = rx_next;
                end
            end
            ST_END: begin
                SS_n     = 1'b1;
                done     = 1'b1;
                rd_valid = rd_q;
                state_d  = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                SS_n    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        // Counter restarts on every state entry so each phase counts from zero.
        if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
        else                                          cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter FRAME_W, default 10, SHALL set the MOSI frame width in bits: 2-bit command followed by address or data.
REQ-002 Parameter DATA_W, default 8, SHALL set the MISO read-data width.
REQ-003 Parameter RD_WAIT, default 2, SHALL set the turnaround cycles between the last MOSI bit and the first MISO bit of a read-data frame.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request pulse; SHALL be accepted only in IDLE.
REQ-007 cmd_data  input  FRAME_W  frame to send; [9:8]=command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0]=payload.
REQ-008 busy  output  1  high from the cycle after acceptance until the END cycle inclusive.
REQ-009 done  output  1  one-cycle pulse marking frame completion.
REQ-010 rd_data  output  DATA_W  byte received on MISO; holds its value until the next rd-data frame completes.
REQ-011 rd_valid  output  1  one-cycle pulse, coincident with done, for command 11 only.
REQ-012 SS_n  output  1  slave select, active-low.
REQ-013 MOSI  output  1  serial data to the slave, MSB first.
REQ-014 MISO  input  1  serial data from the slave, MSB first.

Function
REQ-015 FSM states SHALL be IDLE, START, SHIFT, WAIT, RECV, END.
REQ-016 IDLE with start=1 SHALL latch cmd_data and go to START; start while busy SHALL be ignored and not queued.
REQ-017 START SHALL last 1 cycle with SS_n=0, MOSI=0, then go to SHIFT.
REQ-018 SHIFT SHALL last FRAME_W cycles, driving cmd_data[FRAME_W-1] down to [0], one bit per cycle, with SS_n=0.
REQ-019 After SHIFT, command 11 SHALL go to WAIT; all other commands SHALL go to END.
REQ-020 WAIT SHALL last RD_WAIT cycles with SS_n=0 and MOSI=0, then go to RECV.
REQ-021 RECV SHALL last DATA_W cycles, sampling MISO at each rising edge into a left-shifting register (first sample becomes the MSB).
REQ-022 END SHALL last 1 cycle with SS_n=1, done=1, rd_valid=1 if command 11, and rd_data updated in the same cycle; the FSM then returns to IDLE.
REQ-023 Timing with acceptance in cycle 0: SS_n low in cycles 1..11 with done in cycle 12 for commands 00/01/10; SS_n low in cycles 1..21 with done in cycle 22 for command 11 (RD_WAIT=2).
REQ-024 start asserted in the END cycle SHALL be ignored; back-to-back frames SHALL therefore have at least 1 idle cycle with SS_n=1.
REQ-025 The bit counter SHALL be sized $clog2(FRAME_W+1) bits and SHALL clear on every state entry; it SHALL never wrap inside a state.
REQ-026 cmd_data changes after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, and clear the counter and shift registers.
REQ-028 Reset mid-frame SHALL abort the frame: no done or rd_valid pulse, and rd_data=0.
REQ-029 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package spi_pkg SHALL hold the command encodings (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11), the FSM state encoding, and the default widths.
REQ-031 One sub-module, spi_master_shreg (parallel-load TX shift-out plus RX shift-in with load and shift enables), SHALL be used; the FSM and counter SHALL stay in spi_master.

Verification
REQ-032 Write address 10'h0_3C -> MOSI bits 0,0,0,0,1,1,1,1,0,0 in cycles 2..11; done in cycle 12; rd_valid stays 0.
REQ-033 Read data 10'h3_00 with MISO driven 8'hA5 in cycles 14..21 -> done and rd_valid in cycle 22, rd_data=8'hA5.
REQ-034 start pulsed in cycles 5 and 12 of a write frame -> both ignored; exactly one done.
REQ-035 rst asserted in cycle 16 of a read frame -> SS_n=1 in the same cycle, no done, rd_data=8'h00.
REQ-036 Full loop with the team's SPI slave and 256-byte RAM: wr-addr 8'h10, wr-data 8'h5A, rd-addr 8'h10, rd-data -> rd_data=8'h5A.
